// File: rtl/exu_dp_issue.sv
// Two-stage issue/result pipeline in front of the shared EXU datapath.
// S1 holds the op and drives the datapath combinationally; S2 captures the result for writeback.
module exu_dp_issue #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       in_sel_i,
  input  logic [3:0]       in_func_i,
  input  logic [31:0]      in_op1_i,
  input  logic [31:0]      in_op2_i,
  input  logic [31:0]      in_jop1_i,
  input  logic [31:0]      in_jop2_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             req_alu_o,
  output logic             req_bjp_o,
  output logic             req_mem_o,
  output logic             req_csr_o,
  output logic [31:0]      dp_op1_o,
  output logic [31:0]      dp_op2_o,
  output logic [31:0]      dp_jop1_o,
  output logic [31:0]      dp_jop2_o,
  output logic [9:0]       alu_flag_o,
  output logic [6:0]       bjp_flag_o,
  output logic [2:0]       csr_flag_o,
  input  logic [31:0]      alu_res_i,
  input  logic [31:0]      bjp_res_i,
  input  logic             bjp_cmp_res_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_res_o,
  output logic             out_cmp_o,
  output logic             out_err_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  logic             s1_valid;
  logic [3:0]       s1_sel;
  logic [3:0]       s1_func;
  logic [31:0]      s1_op1;
  logic [31:0]      s1_op2;
  logic [31:0]      s1_jop1;
  logic [31:0]      s1_jop2;
  logic [TAG_W-1:0] s1_tag;

  logic s1_legal;
  logic s1_live;
  logic s2_free;
  logic s1_adv;
  logic accept;
  logic handoff;

  always_comb begin
    s1_legal = 1'b0;
    case (s1_sel)
      4'b0001: s1_legal = (s1_func < 4'd10);
      4'b0010: s1_legal = (s1_func < 4'd7);
      4'b0100: s1_legal = 1'b1;
      4'b1000: s1_legal = (s1_func < 4'd3);
      default: s1_legal = 1'b0;
    endcase
  end

  // Datapath sees nothing unless a legal op sits in S1.
  assign s1_live    = s1_valid & s1_legal;
  assign req_alu_o  = s1_live & s1_sel[0];
  assign req_bjp_o  = s1_live & s1_sel[1];
  assign req_mem_o  = s1_live & s1_sel[2];
  assign req_csr_o  = s1_live & s1_sel[3];
  assign alu_flag_o = req_alu_o ? (10'd1 << s1_func) : 10'd0;
  assign bjp_flag_o = req_bjp_o ? (7'd1 << s1_func) : 7'd0;
  assign csr_flag_o = req_csr_o ? (3'd1 << s1_func) : 3'd0;
  assign dp_op1_o   = s1_live ? s1_op1  : 32'd0;
  assign dp_op2_o   = s1_live ? s1_op2  : 32'd0;
  assign dp_jop1_o  = s1_live ? s1_jop1 : 32'd0;
  assign dp_jop2_o  = s1_live ? s1_jop2 : 32'd0;

  assign s2_free    = ~out_valid_o | out_ready_i;
  assign s1_adv     = s1_valid & s2_free;
  assign in_ready_o = ~flush_i & (~s1_valid | s2_free);
  assign accept     = in_valid_i & in_ready_o;
  assign handoff    = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s1_func  <= '0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      s1_jop1  <= '0;
      s1_jop2  <= '0;
      s1_tag   <= '0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sel   <= in_sel_i;
      s1_func  <= in_func_i;
      s1_op1   <= in_op1_i;
      s1_op2   <= in_op2_i;
      s1_jop1  <= in_jop1_i;
      s1_jop2  <= in_jop2_i;
      s1_tag   <= in_tag_i;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_res_o   <= '0;
      out_cmp_o   <= 1'b0;
      out_err_o   <= 1'b0;
      out_tag_o   <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (s1_adv) begin
      out_valid_o <= 1'b1;
      out_err_o   <= ~s1_legal;
      out_tag_o   <= s1_tag;
      out_res_o   <= ~s1_legal ? 32'd0 : (s1_sel[1] ? bjp_res_i : alu_res_i);
      // A jump is always taken; conditional branches take the datapath compare.
      out_cmp_o   <= s1_live & s1_sel[1] & ((s1_func == 4'd6) | bjp_cmp_res_i);
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // A hand-off coinciding with a flush still completes on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_o <= '0;
    end else if (handoff) begin
      retire_cnt_o <= retire_cnt_o + 1'b1;
    end
  end

endmodule
